// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10 bits clocked by the device, ack check.
// Optional device-silence timeout is enabled with `define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int INHIBIT_CYC = CLK_HZ / 10_000,
    parameter int REQ_CYC     = 16,
    parameter int TIMEOUT_CYC = (CLK_HZ / 1000) * 15
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       wr_i,
    input  logic [7:0] din_i,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic       ps2c_oe_o,
    output logic       ps2d_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INH   = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    // One counter times the host-owned phases and, when enabled, the device-silence window.
    localparam int CNT_MAX0 = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYC) ? CNT_MAX0 : TIMEOUT_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYC - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       sh_q, sh_d;
    logic             c_oe_q, c_oe_d;
    logic             d_oe_q, d_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic c_meta_q, c_sync_q, c_prev_q;
    logic d_meta_q, d_sync_q;
    logic fall;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            c_prev_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
        end else begin
            c_meta_q <= ps2c_i;
            c_sync_q <= c_meta_q;
            c_prev_q <= c_sync_q;
            d_meta_q <= ps2d_i;
            d_sync_q <= d_meta_q;
        end
    end

    assign fall = c_prev_q & ~c_sync_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        c_oe_d  = c_oe_q;
        d_oe_d  = d_oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (wr_i) begin
                    sh_d    = {1'b1, ~^din_i, din_i};
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    c_oe_d  = 1'b1;
                    d_oe_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_INH;
                end
            end
            S_INH: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    d_oe_d  = 1'b1;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                // Releasing the clock while data stays low hands clocking to the device.
                if (cnt_q == REQ_LAST) begin
                    cnt_d   = '0;
                    c_oe_d  = 1'b0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    d_oe_d = ~sh_q[bit_q];
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 4'd9) state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (d_sync_q) err_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (c_sync_q && d_sync_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        if (state_q == S_SHIFT || state_q == S_ACK || state_q == S_WAIT) begin
            if (fall) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
                cnt_d   = '0;
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ps2c_oe_o = c_oe_q;
    assign ps2d_oe_o = d_oe_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a frame scoreboard.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int REQ  = 16;
    localparam int TO   = 1000;
    localparam int HALF = 40;

    typedef struct {
        logic [10:0] bits;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_line, ps2d_line;
    logic       ps2c_oe, ps2d_oe, busy, done, err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   inh_run = 0;
    logic d_oe_prev = 1'b0;
    exp_t sb[$];

    assign ps2c_line = ~(ps2c_oe | dev_c_low);
    assign ps2d_line = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .CLK_HZ(50_000_000), .INHIBIT_CYC(INH), .REQ_CYC(REQ), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .wr_i(wr), .din_i(din),
        .ps2c_i(ps2c_line), .ps2d_i(ps2d_line),
        .ps2c_oe_o(ps2c_oe), .ps2d_oe_o(ps2d_oe),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Done pulses, inhibit length, and quiet lines while idle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && ps2c_oe && !ps2d_oe) begin
            inh_run++;
        end else begin
            if (rst_n && ps2c_oe && ps2d_oe && !d_oe_prev) chk("inhibit_len", inh_run, INH);
            inh_run = 0;
        end
        d_oe_prev = ps2d_oe;
        if (rst_n && !busy) chk("idle_oe", {ps2c_oe, ps2d_oe}, 0);
    end

    task automatic wait_rts(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy && !ps2c_oe && ps2d_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device clocks nfalls falls; samples start before the first fall, then each bit in the high phase.
    task automatic dev_clocks(input int nfalls, input bit ack, output logic [10:0] bits);
        bits = '0;
        repeat (HALF) @(negedge clk);
        bits[0] = ps2d_line;
        for (int k = 1; k <= nfalls && k <= 10; k++) begin
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (HALF) @(negedge clk);
            bits[k] = ps2d_line;
        end
        if (nfalls >= 11) begin
            dev_d_low = ack;
            repeat (4) @(negedge clk);
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            dev_d_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_wr(input logic [7:0] b);
        @(negedge clk);
        din = b;
        wr  = 1'b1;
        @(negedge clk);
        wr  = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] b, input bit ack, input bit dup_wr, output logic [10:0] got);
        exp_t e;
        bit   ok, seen;
        int   d0;
        e.bits = {1'b1, ~^b, b, 1'b0};
        e.err  = !ack;
        sb.push_back(e);
        start_wr(b);
        chk("wr_to_c_low", ps2c_oe, 1);
        chk("busy_set", busy, 1);
        chk("err_clr_on_wr", err, 0);
        d0 = done_cnt;
        if (dup_wr) begin
            repeat (99) @(negedge clk);
            din = 8'h55;
            wr  = 1'b1;
            @(negedge clk);
            wr  = 1'b0;
        end
        wait_rts(ok);
        chk("rts_seen", ok, 1);
        dev_clocks(11, ack, got);
        wait_done(500, seen);
        chk("done_seen", seen, 1);
        e = sb.pop_front();
        chk("frame", got, e.bits);
        chk("err", err, e.err);
        chk("busy_clr", busy, 0);
        repeat (20) @(negedge clk);
        chk("one_done", done_cnt - d0, 1);
    endtask

    initial begin
        logic [10:0] got;
        bit ok, seen;
        int d0;

        repeat (4) @(negedge clk);
        chk("rst_c_oe", ps2c_oe, 0);
        chk("rst_d_oe", ps2d_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        xfer(8'hED, 1'b1, 1'b0, got);
        chk("frame_ED_const", got, 11'h7DA);
        xfer(8'h07, 1'b1, 1'b0, got);
        chk("parity_07", got[9], 0);
        xfer(8'h00, 1'b1, 1'b0, got);
        chk("parity_00", got[9], 1);

        xfer(8'hC3, 1'b0, 1'b0, got);
        xfer(8'hAA, 1'b1, 1'b1, got);

        // Reset in the middle of the data bits.
        start_wr(8'hA5);
        wait_rts(ok);
        chk("rts_seen_rst", ok, 1);
        dev_clocks(4, 1'b0, got);
        chk("mid_busy", busy, 1);
        chk("mid_d_oe", ps2d_oe, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_c_oe", ps2c_oe, 0);
        chk("mrst_d_oe", ps2d_oe, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_err", err, 0);
        repeat (5) @(negedge clk);
        xfer(8'hFF, 1'b1, 1'b0, got);

        // Device goes silent after three falls.
        start_wr(8'hF4);
        wait_rts(ok);
        chk("rts_seen_to", ok, 1);
        d0 = done_cnt;
        dev_clocks(3, 1'b0, got);
`ifdef PS2_TX_TIMEOUT_EN
        wait_done(TO + 500, seen);
        chk("to_done", seen, 1);
        chk("to_err", err, 1);
        chk("to_c_oe", ps2c_oe, 0);
        chk("to_d_oe", ps2d_oe, 0);
        chk("to_busy", busy, 0);
`else
        repeat (2 * TO) @(negedge clk);
        chk("silent_busy", busy, 1);
        chk("silent_no_done", done_cnt - d0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("silent_rst_busy", busy, 0);
`endif
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
